grf_sb: RTL and testbench

// - Parametrised general register file for the pipelined MIPS core, with write-through bypass and a per-register pending-write scoreboard.
// - Serves NUM_RD read ports from one write port. Tracks writes still in flight (multi-cycle mult/div, long pipes) so the hazard unit stalls on busy operands.
// - Sits in the D stage: reads in D, issue marks in D, writeback arrives from W.

---
 rtl/grf_sb.sv | 135 +++++++++++++
 tb/tb_grf_sb.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_sb.sv
// ---------------------------------------------------------------------------
// grf_sb : general register file with write-through bypass and a per-register
//          pending-write scoreboard for the D stage of the pipelined MIPS core.
//
// Register 0 reads as zero and is never written or counted. Each other
// register r has an outstanding-write counter cnt[r]:
//    - an accepted issue to r adds one;
//    - a writeback to r removes one;
//    - an issue and a writeback to r in the same cycle cancel out.
// The hazard unit stalls on rd_busy.
//
// Parameters
//   DATA_W  register width
//   ADDR_W  register address width (depth = 2**ADDR_W)
//   NUM_RD  number of read ports
//   CNT_W   outstanding-write counter width (max = 2**CNT_W-1)
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   we, wa, wd           writeback enable / address / data (from W)
//   w_pc                 PC of the writing instruction (trace output only)
//   iss_en, iss_addr     issue of an instruction writing iss_addr
//   iss_ready            issue accepted this cycle when iss_en && iss_ready
//   rd_addr, rd_data     packed read ports, port k at [k*W +: W]
//   rd_busy              port k operand still has a write in flight
//   sb_err               sticky: writeback arrived with nothing outstanding
//
// Configuration macro
//   GRF_TRACE_EN  when defined, each register write is printed, and a warning
//                 is printed when sb_err first sets.
// ---------------------------------------------------------------------------
module grf_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   input  logic [31:0]              w_pc,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic                     iss_ready,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic                     sb_err
);

   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [CNT_W-1:0]  cnt  [DEPTH];
   logic              sb_err_q;

   logic              wb_act;
   logic              iss_act;
   logic              err_set;
   logic [DEPTH-1:0]  inc_v;
   logic [DEPTH-1:0]  dec_v;

   assign wb_act = we && (wa != '0);

   // A full counter can still take an issue when the same register retires
   // one write this cycle: the two cancel and the count stays at max.
   assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) ||
                      (we && (wa == iss_addr));

   assign iss_act = iss_en && iss_ready && (iss_addr != '0);

   // Untracked writeback: nothing outstanding and no issue cancelling it.
   assign err_set = wb_act && (cnt[wa] == '0) && !(iss_act && (iss_addr == wa));

   always_comb begin
      inc_v = '0;
      dec_v = '0;
      if (iss_act) inc_v[iss_addr] = 1'b1;
      if (wb_act)  dec_v[wa]       = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         if (wb_act) regs[wa] <= wd;
         for (int r = 0; r < DEPTH; r++) begin
            if (inc_v[r] && !dec_v[r]) begin
               cnt[r] <= cnt[r] + CNT_ONE;
            end else if (dec_v[r] && !inc_v[r] && (cnt[r] != '0)) begin
               cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
         sb_err_q <= sb_err_q | err_set;
      end
   end

   assign sb_err = sb_err_q;

   // Read ports: combinational, with write-through of the current writeback.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              hit;
      assign a   = rd_addr[k*ADDR_W +: ADDR_W];
      assign hit = we && (wa == a);
      assign rd_data[k*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                           hit        ? wd : regs[a];
      // The last outstanding write being bypassed now makes the operand usable.
      assign rd_busy[k] = (a != '0) && (cnt[a] != '0) &&
                          !(hit && (cnt[a] == CNT_ONE));
   end

`ifdef GRF_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && wb_act) begin
         $display("%d@%h: $%d <= %h", $time, w_pc, wa, wd);
      end
      if (!reset && err_set && !sb_err_q) begin
         $display("%d@%h: grf_sb warning: untracked writeback to $%d", $time, w_pc, wa);
      end
   end
`else
   logic unused_w_pc;
   assign unused_w_pc = ^w_pc;
`endif

endmodule

// File: tb/tb_grf_sb.sv
// ---------------------------------------------------------------------------
// tb_grf_sb : self-checking bench for grf_sb (default parameters).
// A reference model holds register contents and outstanding-write counts as
// plain integers and predicts every DUT output.
// ---------------------------------------------------------------------------
module tb_grf_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int CNT_W  = 2;
   localparam int MAXC   = 3;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     we;
   logic [ADDR_W-1:0]        wa;
   logic [DATA_W-1:0]        wd;
   logic [31:0]              w_pc;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_ready;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     sb_err;

   int nvec = 0;
   int nerr = 0;

   int unsigned mreg [32];
   int          mcnt [32];
   bit          merr;

   always #5 clk = ~clk;

   grf_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .w_pc(w_pc),
      .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .sb_err(sb_err)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] exp_data(int a);
      if (a == 0) return 32'h0;
      if (we && int'(wa) == a) return wd;
      return mreg[a];
   endfunction

   function automatic logic exp_busy(int a);
      if (a == 0) return 1'b0;
      if (mcnt[a] == 0) return 1'b0;
      if (we && int'(wa) == a && mcnt[a] == 1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_ready();
      if (iss_addr == 0) return 1'b1;
      if (mcnt[iss_addr] < MAXC) return 1'b1;
      return (we && wa == iss_addr);
   endfunction

   // Advance the model with the current inputs, then clock the DUT.
   task automatic tick();
      bit acc;
      bit wb;
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            mreg[r] = 0;
            mcnt[r] = 0;
         end
         merr = 0;
      end else begin
         acc = iss_en && exp_ready() && iss_addr != 0;
         wb  = we && wa != 0;
         if (wb) mreg[wa] = wd;
         if (acc && !(wb && wa == iss_addr)) mcnt[iss_addr]++;
         if (wb && !(acc && iss_addr == wa)) begin
            if (mcnt[wa] > 0) mcnt[wa]--;
            else merr = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; we = 0; wa = 0; wd = 0; w_pc = 0; iss_en = 0; iss_addr = 0;
   endtask

   task automatic set_rd(int a0, int a1);
      logic [4:0] p0;
      logic [4:0] p1;
      p0 = a0[4:0];
      p1 = a1[4:0];
      rd_addr = {p1, p0};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      reset = 1;
      tick();
      reset = 0;
      for (int a = 0; a < 32; a++) begin
         set_rd(a, 31 - a);
         iss_addr = a[4:0];
         #1;
         nvec++;
         if (rd_data !== 64'h0) begin
            nerr++;
            $display("FAIL reset_rd_data addr=%0d actual=%h required=0", a, rd_data);
         end
         nvec++;
         if (rd_busy !== 2'b00) begin
            nerr++;
            $display("FAIL reset_rd_busy addr=%0d actual=%b required=00", a, rd_busy);
         end
         nvec++;
         if (iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_iss_ready addr=%0d actual=%b required=1", a, iss_ready);
         end
      end
      nvec++;
      if (sb_err !== 1'b0) begin
         nerr++;
         $display("FAIL reset_sb_err actual=%b required=0", sb_err);
      end
      idle();
   endtask

   task automatic test_bypass();
      idle();
      we = 1; wa = 5; wd = 32'hDEADBEEF; w_pc = 32'h0040_0010;
      set_rd(5, 0);
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL bypass_same_cycle actual=%h required=DEADBEEF", rd_data[31:0]);
      end
      nvec++;
      if (rd_data[63:32] !== 32'h0) begin
         nerr++;
         $display("FAIL bypass_port1_r0 actual=%h required=0", rd_data[63:32]);
      end
      tick();
      idle();
      #1;
      nvec++;
      if (rd_data[31:0] !== 32'hDEADBEEF) begin
         nerr++;
         $display("FAIL bypass_stored actual=%h required=DEADBEEF", rd_data[31:0]);
      end
   endtask

   task automatic test_zero_reg();
      idle();
      we = 1; wa = 0; wd = 32'h1234;
      set_rd(0, 0);
      #1;
      nvec++;
      if (rd_data !== 64'h0) begin
         nerr++;
         $display("FAIL zero_reg_bypass actual=%h required=0", rd_data);
      end
      tick();
      idle();
      #1;
      nvec++;
      if (rd_data !== 64'h0) begin
         nerr++;
         $display("FAIL zero_reg_stored actual=%h required=0", rd_data);
      end
   endtask

   task automatic test_saturate();
      idle();
      reset = 1;
      tick();
      idle();
      set_rd(8, 8);
      iss_en = 1; iss_addr = 8;
      for (int i = 0; i < MAXC; i++) begin
         #1;
         nvec++;
         if (iss_ready !== 1'b1) begin
            nerr++;
            $display("FAIL sat_ready_fill step=%0d actual=%b required=1", i, iss_ready);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         #1;
         nvec++;
         if (iss_ready !== 1'b0) begin
            nerr++;
            $display("FAIL sat_ready_full step=%0d actual=%b required=0", i, iss_ready);
         end
         nvec++;
         if (rd_busy !== 2'b11) begin
            nerr++;
            $display("FAIL sat_busy_full step=%0d actual=%b required=11", i, rd_busy);
         end
         tick();
      end
      iss_en = 0;
      we = 1; wa = 8; wd = 32'hA;
      #1;
      nvec++;
      if (iss_ready !== 1'b1) begin
         nerr++;
         $display("FAIL sat_ready_with_wb actual=%b required=1", iss_ready);
      end
      tick();
      we = 0;
      #1;
      nvec++;
      if (iss_ready !== 1'b1 || rd_busy !== 2'b11 || rd_data[31:0] !== 32'hA) begin
         nerr++;
         $display("FAIL sat_after_wb1 actual=%b/%b/%h required=1/11/0000000a",
                  iss_ready, rd_busy, rd_data[31:0]);
      end
      we = 1; wd = 32'hB;
      tick();
      wd = 32'hC;
      #1;
      nvec++;
      if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'hC) begin
         nerr++;
         $display("FAIL sat_last_wb actual=%b/%h required=00/0000000c", rd_busy, rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      nvec++;
      if (rd_busy !== 2'b00 || rd_data[63:32] !== 32'hC || sb_err !== 1'b0) begin
         nerr++;
         $display("FAIL sat_drained actual=%b/%h/%b required=00/0000000c/0",
                  rd_busy, rd_data[63:32], sb_err);
      end
   endtask

   task automatic test_same_cycle();
      idle();
      set_rd(9, 10);
      iss_en = 1; iss_addr = 9;
      tick();
      we = 1; wa = 9; wd = 32'h99;
      #1;
      nvec++;
      if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h99) begin
         nerr++;
         $display("FAIL same_cycle_bypass actual=%b/%h required=0/00000099", rd_busy[0], rd_data[31:0]);
      end
      tick();
      idle();
      #1;
      nvec++;
      if (rd_busy[0] !== 1'b1) begin
         nerr++;
         $display("FAIL same_cycle_cnt_kept actual=%b required=1", rd_busy[0]);
      end
      we = 1; wa = 10; wd = 32'h1010;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         nvec++;
         if (sb_err !== 1'b1 || rd_data[63:32] !== 32'h1010) begin
            nerr++;
            $display("FAIL untracked_wb step=%0d actual=%b/%h required=1/00001010",
                     i, sb_err, rd_data[63:32]);
         end
         tick();
      end
   endtask

   task automatic test_reset_override();
      idle();
      set_rd(3, 3);
      iss_en = 1; iss_addr = 3;
      tick();
      tick();
      idle();
      we = 1; wa = 3; wd = 32'h55;
      tick();
      reset = 1; we = 1; wa = 3; wd = 32'h77; iss_en = 1; iss_addr = 3;
      tick();
      idle();
      iss_addr = 3;
      #1;
      nvec++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00 || sb_err !== 1'b0 || iss_ready !== 1'b1) begin
         nerr++;
         $display("FAIL reset_override actual=%h/%b/%b/%b required=0/00/0/1",
                  rd_data, rd_busy, sb_err, iss_ready);
      end
   endtask

   task automatic test_random();
      int a;
      idle();
      reset = 1;
      tick();
      for (int c = 0; c < 600; c++) begin
         reset    = ($urandom_range(0, 59) == 0);
         we       = ($urandom_range(0, 2) != 0);
         wa       = 5'($urandom_range(0, 7));
         wd       = $urandom;
         w_pc     = $urandom;
         iss_en   = ($urandom_range(0, 1) != 0);
         iss_addr = 5'($urandom_range(0, 7));
         set_rd($urandom_range(0, 7), $urandom_range(0, 7));
         #1;
         for (int k = 0; k < NUM_RD; k++) begin
            a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
            nvec++;
            if (rd_data[k*DATA_W +: DATA_W] !== exp_data(a)) begin
               nerr++;
               $display("FAIL rand_rd_data cyc=%0d port=%0d addr=%0d actual=%h required=%h",
                        c, k, a, rd_data[k*DATA_W +: DATA_W], exp_data(a));
            end
            nvec++;
            if (rd_busy[k] !== exp_busy(a)) begin
               nerr++;
               $display("FAIL rand_rd_busy cyc=%0d port=%0d addr=%0d actual=%b required=%b",
                        c, k, a, rd_busy[k], exp_busy(a));
            end
         end
         nvec++;
         if (iss_ready !== exp_ready()) begin
            nerr++;
            $display("FAIL rand_iss_ready cyc=%0d addr=%0d actual=%b required=%b",
                     c, iss_addr, iss_ready, exp_ready());
         end
         nvec++;
         if (sb_err !== merr) begin
            nerr++;
            $display("FAIL rand_sb_err cyc=%0d actual=%b required=%b", c, sb_err, merr);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      rd_addr = '0;
      reset = 1;
      tick();
      tick();
      reset = 0;
      test_reset();
      test_bypass();
      test_zero_reg();
      test_saturate();
      test_same_cycle();
      test_reset_override();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
